// File: rtl/bcd_seg_scan_if.sv
// Display-side bundle between the BCD source and the 2-digit scan driver.
// The master drives the BCD value and controls; the slave returns the segment drive.
interface bcd_seg_scan_if;
  logic [7:0] bcd;
  logic       load;
  logic       blink_en;
  logic [6:0] seg;
  logic [1:0] an;
  logic       dig_err;

  modport master (output bcd, load, blink_en, input seg, an, dig_err);
  modport slave  (input bcd, load, blink_en, output seg, an, dig_err);
endinterface

// File: rtl/bcd_seg_scan.sv
// Two-digit multiplexed 7-segment driver: holds a packed BCD value and scans
// units/tens onto one active-low segment bus with guard, blink and blanking.
module bcd_seg_scan #(
  parameter int SCAN_DIV    = 50000,
  parameter int GUARD       = 2,
  parameter int BLINK_SLOTS = 250,
  parameter int BLANK_LZ    = 1
) (
  input  logic           clk,
  input  logic           rst,
  bcd_seg_scan_if.slave  bus
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;
  localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_SLOTS - 1);
  localparam bit LZ = (BLANK_LZ != 0);

  logic [7:0]    held_q;
  logic [SW-1:0] slot_cnt_q, slot_cnt_d;
  logic          sel_q, sel_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_ph_q, blink_ph_d;
  logic [3:0]    slot_dig_q;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;
  logic          dig_err_q;

  logic          slot_wrap;
  logic          in_guard;
  logic          blanked;
  logic [3:0]    cur_nib;
  logic [3:0]    digit;
  logic [1:0]    nib_bad;

  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0:    dec7 = 7'h3F;
      4'd1:    dec7 = 7'h06;
      4'd2:    dec7 = 7'h5B;
      4'd3:    dec7 = 7'h4F;
      4'd4:    dec7 = 7'h66;
      4'd5:    dec7 = 7'h6D;
      4'd6:    dec7 = 7'h7D;
      4'd7:    dec7 = 7'h07;
      4'd8:    dec7 = 7'h7F;
      4'd9:    dec7 = 7'h6F;
      default: dec7 = 7'h79;
    endcase
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_nib
    assign nib_bad[gi] = (held_q[gi*4 +: 4] > 4'd9);
  end

  if (GUARD > 0) begin : g_guard
    assign in_guard = (slot_cnt_q < SW'(GUARD));
  end else begin : g_noguard
    assign in_guard = 1'b0;
  end

  // The first cycle of a slot uses the live nibble; the rest of the slot
  // replays the copy taken then, so a mid-slot load cannot tear the digit.
  assign slot_wrap = (slot_cnt_q == SLOT_LAST);
  assign cur_nib   = sel_q ? held_q[7:4] : held_q[3:0];
  assign digit     = (slot_cnt_q == '0) ? cur_nib : slot_dig_q;
  assign blanked   = (bus.blink_en && blink_ph_q) || (sel_q && LZ && (digit == 4'd0));

  always_comb begin
    slot_cnt_d  = slot_cnt_q + 1'b1;
    sel_d       = sel_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    seg_d       = 7'h7F;
    an_d        = 2'b11;
    if (slot_wrap) begin
      slot_cnt_d = '0;
      sel_d      = ~sel_q;
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
    if (!in_guard && !blanked) begin
      seg_d = ~dec7(digit);
      an_d  = sel_q ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held_q      <= 8'h00;
      slot_cnt_q  <= '0;
      sel_q       <= 1'b0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      slot_dig_q  <= 4'h0;
      seg_q       <= 7'h7F;
      an_q        <= 2'b11;
      dig_err_q   <= 1'b0;
    end else begin
      if (bus.load) held_q <= bus.bcd;
      if (slot_cnt_q == '0) slot_dig_q <= cur_nib;
      slot_cnt_q  <= slot_cnt_d;
      sel_q       <= sel_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      dig_err_q   <= |nib_bad;
    end
  end

  assign bus.seg     = seg_q;
  assign bus.an      = an_q;
  assign bus.dig_err = dig_err_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Directed plus random bench for bcd_seg_scan; runs a BLANK_LZ=1 and a
// BLANK_LZ=0 instance side by side against one arithmetic display model.
module tb_bcd_seg_scan;
  localparam int SD = 4;
  localparam int GD = 1;
  localparam int BS = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  // model state: edges since reset, held value, digit frozen at slot start
  int         t;
  logic [7:0] held_m;
  logic [3:0] snap_m;
  logic [6:0] lut [16];

  bcd_seg_scan_if bus0 ();
  bcd_seg_scan_if bus1 ();

  assign bus1.bcd      = bus0.bcd;
  assign bus1.load     = bus0.load;
  assign bus1.blink_en = bus0.blink_en;

  bcd_seg_scan #(.SCAN_DIV(SD), .GUARD(GD), .BLINK_SLOTS(BS), .BLANK_LZ(1)) u_lz (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  bcd_seg_scan #(.SCAN_DIV(SD), .GUARD(GD), .BLINK_SLOTS(BS), .BLANK_LZ(0)) u_nolz (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  function automatic void exp_out(input bit blz, input logic be,
                                  output logic [6:0] s, output logic [1:0] a);
    int pos, slot, sel, ph;
    logic [3:0] nib;
    pos  = t % SD;
    slot = t / SD;
    sel  = slot % 2;
    ph   = (slot / BS) % 2;
    nib  = (pos != 0) ? snap_m : (sel == 1 ? held_m[7:4] : held_m[3:0]);
    s = 7'h7F;
    a = 2'b11;
    if (!(pos < GD) && !(be && ph == 1) && !(sel == 1 && blz && nib == 4'd0)) begin
      s = ~lut[nib];
      a = (sel == 1) ? 2'b01 : 2'b10;
    end
  endfunction

  task automatic step(input logic r, input logic ld, input logic [7:0] b, input logic be);
    logic [6:0] es0, es1;
    logic [1:0] ea0, ea1;
    logic       ee;
    rst = r;
    bus0.load = ld;
    bus0.bcd = b;
    bus0.blink_en = be;
    if (r) begin
      es0 = 7'h7F; es1 = 7'h7F; ea0 = 2'b11; ea1 = 2'b11; ee = 1'b0;
      t = 0; held_m = 8'h00; snap_m = 4'h0;
    end else begin
      exp_out(1'b1, be, es0, ea0);
      exp_out(1'b0, be, es1, ea1);
      ee = (held_m[7:4] > 9) || (held_m[3:0] > 9);
      if (t % SD == 0) snap_m = ((t / SD) % 2 == 1) ? held_m[7:4] : held_m[3:0];
      if (ld) held_m = b;
      t++;
    end
    @(posedge clk);
    #1;
    $display("t=%0d rst=%0b load=%0b bcd=%h blink=%0b | seg=%h an=%b err=%0b | seg_nolz=%h an_nolz=%b",
             t, r, ld, b, be, bus0.seg, bus0.an, bus0.dig_err, bus1.seg, bus1.an);
    check("seg_lz",  {1'b0, bus0.seg}, {1'b0, es0});
    check("an_lz",   {6'b0, bus0.an},  {6'b0, ea0});
    check("err_lz",  {7'b0, bus0.dig_err}, {7'b0, ee});
    check("seg_nolz", {1'b0, bus1.seg}, {1'b0, es1});
    check("an_nolz",  {6'b0, bus1.an},  {6'b0, ea1});
    check("err_nolz", {7'b0, bus1.dig_err}, {7'b0, ee});
    check("one_anode", {7'b0, (bus0.an == 2'b00) || (bus1.an == 2'b00)}, 8'h00);
  endtask

  initial begin
    logic       r, ld, be;
    logic [7:0] b;
    lut = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79};
    t = 0; held_m = 8'h00; snap_m = 4'h0;

    // reset with a load pending; the load must be ignored
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'h99, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00, 1'b0);

    step(1'b0, 1'b1, 8'h42, 1'b0);
    for (int i = 0; i < 17; i++) step(1'b0, 1'b0, 8'h00, 1'b0);

    step(1'b0, 1'b1, 8'h07, 1'b0);
    for (int i = 0; i < 17; i++) step(1'b0, 1'b0, 8'h00, 1'b0);

    step(1'b0, 1'b1, 8'h3C, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h12, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00, 1'b0);

    step(1'b0, 1'b1, 8'h55, 1'b1);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 8'h00, 1'b1);

    // mid-units-slot reload: current slot keeps the old digit
    step(1'b0, 1'b1, 8'h12, 1'b0);
    for (int i = 0; i < 2 * SD && (t % (2 * SD)) != 2; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h34, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 8'h00, 1'b0);

    // reset in the middle of a slot
    for (int i = 0; i < SD && (t % SD) != 2; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00, 1'b0);

    be = 1'b0;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(99) == 0);
      ld = ($urandom_range(3) == 0);
      if ($urandom_range(1) == 0) b = {4'($urandom_range(9)), 4'($urandom_range(9))};
      else b = 8'($urandom);
      if ($urandom_range(49) == 0) be = ~be;
      step(r, ld, b, be);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
